serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
Downstream stage of the serial two's-complement converter. Captures the LSB-first serial result bits and assembles them into a parallel WIDTH-bit word. Presents each word on a valid/ready output port through a one-entry hold slot, so the next frame can be collected while the consumer stalls. Flags framing and overrun errors.

Parameters:
WIDTH, 8, bits per serial frame / output word width (>= 2)
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
t_clk  input  1  clock; all state updates on rising edge
r  input  1  asynchronous active-low reset
y_in  input  1  serial data bit from the complementer (LSB first)
bit_valid  input  1  y_in is a valid bit this cycle
sof  input  1  start of frame; qualifies the bit with bit_valid as bit 0
out_word  output  WIDTH  assembled word, bit 0 = first serial bit
out_valid  output  1  out_word holds an unconsumed word
out_ready  input  1  consumer accepts out_word when out_valid && out_ready
busy  output  1  frame collection in progress (state == COLLECT)
frame_err  output  1  one-cycle pulse: frame restarted or stray bit received
overrun  output  1  one-cycle pulse: completed word dropped, hold slot full

Behaviour:
- Reset (r low, asynchronous): state=IDLE, shift register=0, count=0, out_word=0, out_valid=0, busy=0, frame_err=0, overrun=0. Release is synchronous to t_clk. A frame in progress at reset is discarded.
- Shift rule: on each accepted bit, shreg <= {y_in, shreg[WIDTH-1:1]} (right shift, new bit enters MSB). After WIDTH bits, the first bit sits at shreg[0].
- bit_valid=0: no shift, no count change, state held. Gaps between bits are legal.
- States:
  - IDLE:
    - bit_valid && sof: shift in the bit, count=1, go to COLLECT.
    - bit_valid && !sof: bit ignored, frame_err pulses.
    - sof without bit_valid: ignored.
  - COLLECT:
    - bit_valid && !sof: shift, count++.
    - bit_valid && sof: abort the partial frame, treat this bit as bit 0 (count=1, stay in COLLECT), frame_err pulses.
    - When count==WIDTH-1 and bit_valid && !sof: frame complete. Final word = {y_in, shreg[WIDTH-1:1]}. count=0, go to IDLE.
- Completion transfer, same edge as the last bit:
  - If the hold slot is empty, or is being drained this cycle (out_valid && out_ready), load out_word with the final word and set out_valid=1.
  - Otherwise keep the old hold contents and pulse overrun for one cycle; the new word is lost.
- Latency: out_valid rises on the edge that samples the last bit, so it is visible in the following cycle.
- Handshake:
  - out_word is stable while out_valid=1 and not accepted.
  - out_valid falls after acceptance, unless a new word loads in the same cycle, in which case it stays high with the new word.
  - out_ready while out_valid=0 has no effect.
- WIDTH=1 is unsupported. Back-to-back frames with no idle cycle (sof on the cycle after the last bit) are legal and lose no bits.

Decomposition:
- Shared package collector_pkg:
  - state enum {IDLE, COLLECT}
  - default WIDTH constant, shared with the complementer's bench
- Sub-module word_hold_slot(WIDTH): one-entry valid/ready register with load, out_valid, and a drain-in-same-cycle bypass; returns accept/full to the collector FSM for overrun detection. Counter and shift register stay in the top module.

Test Plan (WIDTH=8):
1. Single frame: sof with bit 0, then bits 0,0,1,0,1,1,0,1 on 8 consecutive cycles, out_ready=1 -> out_valid high one cycle after the 8th bit, out_word=8'hB4, busy low afterwards, no error pulses.
2. Gapped bits: same frame with bit_valid low for 3 cycles between bits 3 and 4 -> out_word=8'hB4, out_valid delayed by exactly 3 cycles versus scenario 1.
3. Stalled consumer plus back-to-back frames:
   - out_ready=0, send 8'h01 then 8'hFF back-to-back -> first word held (out_word=8'h01), overrun pulses once at the 8'hFF completion, out_word remains 8'h01.
   - Raise out_ready -> out_valid drops next cycle.
4. Drain-and-load same cycle: assert out_ready exactly on the edge completing a second frame 8'h5A while 8'h3C is held -> 8'h3C accepted, out_word=8'h5A, out_valid stays 1, no overrun.
5. Framing:
   - bit_valid without sof in IDLE -> frame_err one pulse, no state change.
   - sof at bit 5 of a frame -> frame_err pulse, the new frame of 8'hC3 completes correctly.
6. Async reset: drive r low mid-frame after 4 bits and while out_valid=1 -> all outputs 0 immediately without a clock edge; after release, a fresh frame 8'h80 yields out_word=8'h80.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared definitions for the serial word collector and its neighbours in the
// serial two's-complement datapath.
package collector_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_word_collector_if.sv
// Valid/ready word port between the collector's hold slot and its consumer.
interface serial_word_collector_if
  import collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_word, output out_valid, input out_ready);
  modport slave  (input out_word, input out_valid, output out_ready);

endinterface

// File: rtl/word_hold_slot.sv
// One-entry valid/ready hold register. A word may load in the same cycle the
// held word is drained, so back-to-back frames never stall on a ready consumer.
module word_hold_slot
  import collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     t_clk,
  input  logic                     r,
  input  logic                     load_i,
  input  logic [WIDTH-1:0]         word_i,
  output logic                     accept_o,
  output logic                     full_o,
  serial_word_collector_if.master  hold_if
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic             valid_q;
  logic             valid_d;

  assign accept_o          = (!valid_q) || hold_if.out_ready;
  assign full_o            = valid_q;
  assign hold_if.out_word  = word_q;
  assign hold_if.out_valid = valid_q;

  // Next-state for the slot: a load wins over a drain in the same cycle.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (load_i && accept_o) begin
      word_d  = word_i;
      valid_d = 1'b1;
    end else if (valid_q && hold_if.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Assembles LSB-first serial bits into WIDTH-bit words and hands them to a
// one-entry hold slot; flags framing errors and dropped words.
module serial_word_collector
  import collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     t_clk,
  input  logic                     r,
  input  logic                     y_in,
  input  logic                     bit_valid,
  input  logic                     sof,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun,
  serial_word_collector_if.master  out_if
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             frame_err_q;
  logic             frame_err_d;
  logic             overrun_q;
  logic             overrun_d;
  logic [WIDTH-1:0] shifted_s;
  logic             load_s;
  logic             accept_s;
  logic             full_s;

  assign shifted_s = {y_in, shreg_q[WIDTH-1:1]};
  assign busy      = (state_q == COLLECT);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Frame FSM: bit counting, shifting and completion/error detection.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    load_s      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shreg_d = shifted_s;
          count_d = CNT_W'(1);
          state_d = COLLECT;
        end else if (bit_valid) begin
          frame_err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (bit_valid && sof) begin
          // Restart: stale partial bits are shifted out by the new frame.
          shreg_d     = shifted_s;
          count_d     = CNT_W'(1);
          frame_err_d = 1'b1;
        end else if (bit_valid) begin
          shreg_d = shifted_s;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            load_s  = 1'b1;
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign overrun_d = load_s && full_s && !accept_s;

  // Collector state and error pulse registers.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  word_hold_slot #(.WIDTH(WIDTH)) u_hold (
    .t_clk    (t_clk),
    .r        (r),
    .load_i   (load_s),
    .word_i   (shifted_s),
    .accept_o (accept_s),
    .full_o   (full_s),
    .hold_if  (out_if)
  );

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector (WIDTH=8) with hand-computed words.
module tb_serial_word_collector;

  logic t_clk;
  logic r;
  logic y_in;
  logic bit_valid;
  logic sof;
  logic busy;
  logic frame_err;
  logic overrun;
  int   total;
  int   bad;
  int   cyc;
  int   c0;

  serial_word_collector_if #(.WIDTH(8)) out_if ();

  serial_word_collector #(.WIDTH(8)) dut (
    .t_clk     (t_clk),
    .r         (r),
    .y_in      (y_in),
    .bit_valid (bit_valid),
    .sof       (sof),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .out_if    (out_if.master)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge t_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    y_in      = b;
    sof       = s;
    bit_valid = 1'b1;
    @(posedge t_clk);
    #1;
    bit_valid = 1'b0;
    sof       = 1'b0;
    y_in      = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(w[i], (i == 0));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    r = 1'b0; y_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    out_if.out_ready = 1'b0;
    #3;
    check_eq("rst_valid", 32'(out_if.out_valid), 32'd0);
    check_eq("rst_word", 32'(out_if.out_word), 32'h00);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    @(negedge t_clk);
    @(negedge t_clk);
    r = 1'b1;
    tick(1);

    // 1: single frame B4, consumer ready
    out_if.out_ready = 1'b1;
    c0 = cyc;
    send_bits(8'hB4, 0, 6);
    check_eq("s1_early_valid", 32'(out_if.out_valid), 32'd0);
    check_eq("s1_busy_mid", 32'(busy), 32'd1);
    send_bits(8'hB4, 7, 7);
    check_eq("s1_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s1_word", 32'(out_if.out_word), 32'hB4);
    check_eq("s1_busy", 32'(busy), 32'd0);
    check_eq("s1_ferr", 32'(frame_err), 32'd0);
    check_eq("s1_ovr", 32'(overrun), 32'd0);
    check_eq("s1_latency", 32'(cyc - c0), 32'd8);
    tick(1);
    check_eq("s1_drained", 32'(out_if.out_valid), 32'd0);

    // 2: three-cycle gap between bits 3 and 4
    c0 = cyc;
    send_bits(8'hB4, 0, 3);
    tick(3);
    check_eq("s2_gap_busy", 32'(busy), 32'd1);
    check_eq("s2_gap_valid", 32'(out_if.out_valid), 32'd0);
    send_bits(8'hB4, 4, 7);
    check_eq("s2_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s2_word", 32'(out_if.out_word), 32'hB4);
    check_eq("s2_latency", 32'(cyc - c0), 32'd11);
    tick(1);

    // 3: stalled consumer, back-to-back 01 then FF
    out_if.out_ready = 1'b0;
    send_bits(8'h01, 0, 7);
    check_eq("s3_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s3_word1", 32'(out_if.out_word), 32'h01);
    check_eq("s3_ovr_first", 32'(overrun), 32'd0);
    send_bits(8'hFF, 0, 6);
    check_eq("s3_ovr_mid", 32'(overrun), 32'd0);
    send_bits(8'hFF, 7, 7);
    check_eq("s3_ovr_pulse", 32'(overrun), 32'd1);
    check_eq("s3_word_kept", 32'(out_if.out_word), 32'h01);
    tick(1);
    check_eq("s3_ovr_end", 32'(overrun), 32'd0);
    check_eq("s3_word_still", 32'(out_if.out_word), 32'h01);
    out_if.out_ready = 1'b1;
    tick(1);
    check_eq("s3_drop_valid", 32'(out_if.out_valid), 32'd0);

    // 4: drain 3C and load 5A on the same edge
    out_if.out_ready = 1'b0;
    send_bits(8'h3C, 0, 7);
    check_eq("s4_held", 32'(out_if.out_word), 32'h3C);
    send_bits(8'h5A, 0, 6);
    out_if.out_ready = 1'b1;
    send_bits(8'h5A, 7, 7);
    out_if.out_ready = 1'b0;
    check_eq("s4_word", 32'(out_if.out_word), 32'h5A);
    check_eq("s4_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s4_ovr", 32'(overrun), 32'd0);
    out_if.out_ready = 1'b1;
    tick(1);
    check_eq("s4_drained", 32'(out_if.out_valid), 32'd0);

    // 5a: stray bit in IDLE
    send_bit(1'b1, 1'b0);
    check_eq("s5_stray_ferr", 32'(frame_err), 32'd1);
    check_eq("s5_stray_busy", 32'(busy), 32'd0);
    check_eq("s5_stray_valid", 32'(out_if.out_valid), 32'd0);
    tick(1);
    check_eq("s5_ferr_end", 32'(frame_err), 32'd0);

    // 5b: restart at bit 5, new frame C3
    send_bits(8'hFF, 0, 4);
    send_bit(1'b1, 1'b1);
    check_eq("s5_restart_ferr", 32'(frame_err), 32'd1);
    check_eq("s5_restart_busy", 32'(busy), 32'd1);
    send_bits(8'hC3, 1, 7);
    check_eq("s5_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s5_word", 32'(out_if.out_word), 32'hC3);
    check_eq("s5_ferr_done", 32'(frame_err), 32'd0);
    tick(1);

    // 6: async reset mid-frame with a word held
    out_if.out_ready = 1'b0;
    send_bits(8'h5A, 0, 7);
    send_bits(8'hFF, 0, 3);
    check_eq("s6_pre_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s6_pre_busy", 32'(busy), 32'd1);
    #2;
    r = 1'b0;
    #1;
    check_eq("s6_rst_valid", 32'(out_if.out_valid), 32'd0);
    check_eq("s6_rst_word", 32'(out_if.out_word), 32'h00);
    check_eq("s6_rst_busy", 32'(busy), 32'd0);
    check_eq("s6_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("s6_rst_ovr", 32'(overrun), 32'd0);
    @(negedge t_clk);
    r = 1'b1;
    tick(1);
    out_if.out_ready = 1'b1;
    send_bits(8'h80, 0, 7);
    check_eq("s6_word", 32'(out_if.out_word), 32'h80);
    check_eq("s6_valid", 32'(out_if.out_valid), 32'd1);
    check_eq("s6_busy", 32'(busy), 32'd0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
